// File: rtl/rgb2gray_stream.sv
// Streaming RGB888 -> 8-bit BT.601 luma, 2 registered stages, 1 pixel/cycle.
// Raster counter tags the last pixel of each frame; short frames raise a sticky error.
module rgb2gray_stream #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int R_COEF = 77,
    parameter int G_COEF = 150,
    parameter int B_COEF = 29
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [23:0] i_rgb,
    input  logic        i_sof,
    output logic        o_in_ready,
    output logic        o_valid,
    output logic [7:0]  o_gray,
    output logic        o_end,
    input  logic        i_out_ready,
    output logic        o_frame_err
);

    localparam int             NPIX = WIDTH * HEIGHT;
    localparam int             CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0]  LAST = CW'(NPIX - 1);
    localparam logic [15:0]    RC   = 16'(R_COEF);
    localparam logic [15:0]    GC   = 16'(G_COEF);
    localparam logic [15:0]    BC   = 16'(B_COEF);

    logic [CW-1:0] pix_cnt;
    logic [CW-1:0] pix_idx;
    logic          pix_end;
    logic          in_xfer;
    logic          s1_load;
    logic          s2_load;

    logic          s1_vld;
    logic          s1_end;
    logic [15:0]   s1_pr;
    logic [15:0]   s1_pg;
    logic [15:0]   s1_pb;
    logic [15:0]   sum;

    logic          s2_vld;
    logic          s2_end;
    logic [7:0]    s2_gray;
    logic          frame_err;

    // Ready depends only on stage occupancy and downstream ready, never on i_valid.
    always_comb begin
        s2_load = !s2_vld || i_out_ready;
        s1_load = !s1_vld || s2_load;
        in_xfer = i_valid && s1_load;
    end

    always_comb begin
        pix_idx = i_sof ? '0 : pix_cnt;
        pix_end = (pix_idx == LAST);
    end

    // Weights sum to 256, so the rounded sum peaks at 65408 and fits 16 bits.
    assign sum = s1_pr + s1_pg + s1_pb + 16'd128;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pix_cnt   <= '0;
            frame_err <= 1'b0;
        end else if (in_xfer) begin
            pix_cnt <= pix_end ? '0 : pix_idx + CW'(1);
            if (i_sof && (pix_cnt != '0)) begin
                frame_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_vld <= 1'b0;
            s1_end <= 1'b0;
            s1_pr  <= '0;
            s1_pg  <= '0;
            s1_pb  <= '0;
        end else if (s1_load) begin
            s1_vld <= in_xfer;
            if (in_xfer) begin
                s1_end <= pix_end;
                s1_pr  <= 16'(i_rgb[23:16]) * RC;
                s1_pg  <= 16'(i_rgb[15:8])  * GC;
                s1_pb  <= 16'(i_rgb[7:0])   * BC;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_vld  <= 1'b0;
            s2_end  <= 1'b0;
            s2_gray <= '0;
        end else if (s2_load) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_end  <= s1_end;
                s2_gray <= sum[15:8];
            end
        end
    end

    assign o_in_ready  = s1_load;
    assign o_valid     = s2_vld;
    assign o_gray      = s2_gray;
    assign o_end       = s2_end;
    assign o_frame_err = frame_err;

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Randomised bench for rgb2gray_stream on a 4x2 frame, checked against a queue-based luma model.
module tb_rgb2gray_stream;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [23:0] i_rgb = '0;
    logic        i_sof = 1'b0;
    logic        i_out_ready = 1'b1;
    logic        o_in_ready;
    logic        o_valid;
    logic [7:0]  o_gray;
    logic        o_end;
    logic        o_frame_err;

    rgb2gray_stream #(.WIDTH(W), .HEIGHT(H), .R_COEF(77), .G_COEF(150), .B_COEF(29)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_rgb(i_rgb), .i_sof(i_sof),
        .o_in_ready(o_in_ready), .o_valid(o_valid), .o_gray(o_gray), .o_end(o_end),
        .i_out_ready(i_out_ready), .o_frame_err(o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int luma(input logic [23:0] p);
        return (int'(p[23:16]) * 77 + int'(p[15:8]) * 150 + int'(p[7:0]) * 29 + 128) / 256;
    endfunction

    typedef struct {
        int gray;
        int e;
        int t;
    } exp_t;

    exp_t exp_q[$];
    int   obs_g[$];
    int   obs_e[$];
    int   idx_m = 0;
    int   err_m = 0;
    int   ncyc = 0;
    bit   chk_lat = 1'b0;
    bit   prev_stall = 1'b0;
    int   prev_g = 0;
    int   prev_e = 0;

    // Model: every accepted pixel is queued with its expected luma and frame-end tag.
    always @(negedge i_clk) begin : cmp
        int   idx;
        exp_t e;
        ncyc++;
        if (i_rst) begin
            check("rst_o_valid", int'(o_valid), 0);
            check("rst_o_gray", int'(o_gray), 0);
            check("rst_o_end", int'(o_end), 0);
            check("rst_o_frame_err", int'(o_frame_err), 0);
            exp_q.delete();
            idx_m = 0;
            err_m = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", int'(o_valid), 1);
                check("hold_gray", int'(o_gray), prev_g);
                check("hold_end", int'(o_end), prev_e);
            end
            check("frame_err", int'(o_frame_err), err_m);
            if (o_valid && i_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_without_input", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("gray", int'(o_gray), e.gray);
                    check("end_flag", int'(o_end), e.e);
                    if (chk_lat) check("latency", ncyc - e.t, 2);
                    obs_g.push_back(int'(o_gray));
                    obs_e.push_back(int'(o_end));
                end
            end
            prev_stall = o_valid && !i_out_ready;
            prev_g = int'(o_gray);
            prev_e = int'(o_end);
            if (i_valid && o_in_ready) begin
                idx = i_sof ? 0 : idx_m;
                if (i_sof && idx_m != 0) err_m = 1;
                e.gray = luma(i_rgb);
                e.e = (idx == NPIX - 1) ? 1 : 0;
                e.t = ncyc;
                exp_q.push_back(e);
                idx_m = (idx == NPIX - 1) ? 0 : idx + 1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send(input logic [23:0] p, input bit sof);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        i_valid = 1'b1;
        i_rgb = p;
        i_sof = sof;
        do begin
            @(negedge i_clk);
            acc = o_in_ready;
            @(posedge i_clk);
            #1;
            n++;
        end while (!acc && n < 5000);
        check("send_accepted", int'(acc), 1);
        i_valid = 1'b0;
        i_sof = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        i_out_ready = 1'b1;
        while ((exp_q.size() != 0 || o_valid) && n < 3000) begin
            cyc(1);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_sof = 1'b0;
        cyc(1);
        i_rst = 1'b0;
        obs_g.delete();
        obs_e.delete();
    endtask

    task automatic stream_rand(input int n);
        for (int k = 0; k < n; k++) send(24'($urandom), k == 0);
    endtask

    logic [23:0] col [6];
    int          colg [6];
    logic [23:0] pix [20];
    int          g1 [$];
    int          e1 [$];

    initial begin : main
        col  = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF, {8'd100, 8'd150, 8'd200}};
        colg = '{255, 0, 77, 149, 29, 141};
        cyc(2);
        i_rst = 1'b0;

        // Colour values, unstalled latency
        chk_lat = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(col[i], i == 0);
            check("colour_in_ready", int'(o_in_ready), 1);
        end
        drain();
        chk_lat = 1'b0;
        check("colour_count", obs_g.size(), 6);
        for (int i = 0; i < 6 && i < obs_g.size(); i++) begin
            check("model_luma", luma(col[i]), colg[i]);
            check("colour_gray", obs_g[i], colg[i]);
        end

        // Frame boundary
        do_reset();
        stream_rand(16);
        drain();
        check("frame_count", obs_e.size(), 16);
        for (int k = 0; k < obs_e.size(); k++) check("frame_end_pos", obs_e[k], (k % 8 == 7) ? 1 : 0);
        check("frame_no_err", int'(o_frame_err), 0);

        // Short backpressure
        do_reset();
        fork
            stream_rand(40);
            begin
                cyc(8);
                i_out_ready = 1'b0;
                cyc(2);
                check("bp_in_ready_fall", int'(o_in_ready), 0);
                cyc(8);
                i_out_ready = 1'b1;
                cyc(1);
                check("bp_in_ready_resume", int'(o_in_ready), 1);
            end
        join
        drain();
        check("bp_count", obs_g.size(), 40);

        // LUT-build stall
        do_reset();
        fork
            stream_rand(20);
            begin
                cyc(5);
                i_out_ready = 1'b0;
                cyc(2);
                check("lut_in_ready_fall", int'(o_in_ready), 0);
                cyc(510);
                check("lut_in_ready_held", int'(o_in_ready), 0);
                i_out_ready = 1'b1;
                cyc(1);
                check("lut_in_ready_resume", int'(o_in_ready), 1);
            end
        join
        drain();
        check("lut_count", obs_g.size(), 20);

        // Random ready with random input gaps
        do_reset();
        fork
            for (int k = 0; k < 60; k++) begin
                while ($urandom_range(0, 1) == 1) cyc(1);
                send(24'($urandom), k == 0);
            end
            repeat (200) begin
                i_out_ready = 1'($urandom_range(0, 1));
                cyc(1);
            end
        join
        drain();
        check("rand_count", obs_g.size(), 60);

        // Short frame
        do_reset();
        for (int k = 0; k < 5; k++) send(24'($urandom), k == 0);
        check("short_err_before", int'(o_frame_err), 0);
        send(24'($urandom), 1'b1);
        check("short_err_after", int'(o_frame_err), 1);
        for (int k = 0; k < 10; k++) send(24'($urandom), 1'b0);
        drain();
        check("short_count", obs_e.size(), 16);
        for (int k = 0; k < obs_e.size(); k++) check("short_end_pos", obs_e[k], (k == 12) ? 1 : 0);
        check("short_err_sticky", int'(o_frame_err), 1);

        // Reset with two pixels in flight
        send(24'($urandom), 1'b0);
        send(24'($urandom), 1'b0);
        do_reset();
        check("rst_err_clear", int'(o_frame_err), 0);
        for (int k = 0; k < 8; k++) send(24'($urandom), 1'b0);
        drain();
        check("rst_count", obs_e.size(), 8);
        for (int k = 0; k < obs_e.size(); k++) check("rst_end_pos", obs_e[k], (k == 7) ? 1 : 0);

        // Idle gaps versus gap-free run
        for (int k = 0; k < 20; k++) pix[k] = 24'($urandom);
        do_reset();
        for (int k = 0; k < 20; k++) send(pix[k], 1'b0);
        drain();
        g1 = obs_g;
        e1 = obs_e;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            while ($urandom_range(0, 1) == 1) cyc(1);
            send(pix[k], 1'b0);
        end
        drain();
        check("gap_count", obs_g.size(), g1.size());
        for (int k = 0; k < g1.size() && k < obs_g.size(); k++) begin
            check("gap_gray", obs_g[k], g1[k]);
            check("gap_end", obs_e[k], e1[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
